// File: rtl/stage_mem_pkg.sv
// -----------------------------------------------------------------------------
// stage_mem_pkg
// Shared definitions for the memory-access pipeline stage: operator codes,
// enable/disable encodings, the MEM stage FSM state encoding and small
// operator-classification helpers used by stage_mem and mem_align.
// -----------------------------------------------------------------------------
package stage_mem_pkg;

   // Operator codes carried down the pipeline from decode
   localparam logic [7:0] OPERATOR_NOP = 8'h00;
   localparam logic [7:0] OPERATOR_ADD = 8'h01;
   localparam logic [7:0] OPERATOR_SUB = 8'h02;
   localparam logic [7:0] OPERATOR_AND = 8'h03;
   localparam logic [7:0] OPERATOR_OR  = 8'h04;
   localparam logic [7:0] OPERATOR_LB  = 8'h20;
   localparam logic [7:0] OPERATOR_LBU = 8'h21;
   localparam logic [7:0] OPERATOR_LH  = 8'h22;
   localparam logic [7:0] OPERATOR_LHU = 8'h23;
   localparam logic [7:0] OPERATOR_LW  = 8'h24;
   localparam logic [7:0] OPERATOR_SB  = 8'h28;
   localparam logic [7:0] OPERATOR_SH  = 8'h29;
   localparam logic [7:0] OPERATOR_SW  = 8'h2A;
   localparam logic [7:0] OPERATOR_LL  = 8'h2C;
   localparam logic [7:0] OPERATOR_SC  = 8'h2D;

   localparam logic RESET_ENABLE  = 1'b1;
   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;
   localparam logic STALL_ENABLE  = 1'b1;
   localparam logic STALL_DISABLE = 1'b0;

   typedef enum logic [1:0] {
      MEM_STATE_IDLE = 2'd0,
      MEM_STATE_WAIT = 2'd1,
      MEM_STATE_DONE = 2'd2
   } mem_state_t;

   function automatic logic op_is_load(input logic [7:0] op);
      return (op == OPERATOR_LB) || (op == OPERATOR_LBU) || (op == OPERATOR_LH) ||
             (op == OPERATOR_LHU) || (op == OPERATOR_LW) || (op == OPERATOR_LL);
   endfunction

   function automatic logic op_is_store(input logic [7:0] op);
      return (op == OPERATOR_SB) || (op == OPERATOR_SH) || (op == OPERATOR_SW) ||
             (op == OPERATOR_SC);
   endfunction

   function automatic logic op_is_mem(input logic [7:0] op);
      return op_is_load(op) || op_is_store(op);
   endfunction

endpackage

// File: rtl/mem_align.sv
// -----------------------------------------------------------------------------
// mem_align
// Combinational big-endian byte-lane logic for the memory stage.
//   i_operator    : operator code (LL treated as LW, SC as SW)
//   i_addr_low    : effective address bits [1:0]
//   i_store_data  : raw store operand
//   i_read_data   : captured bus read word
//   o_byte_select : lane enables, bit 3 = lane [31:24]
//   o_write_data  : store data replicated across lanes
//   o_load_data   : selected lane(s), sign- or zero-extended to 32 bits
// -----------------------------------------------------------------------------
module mem_align
   import stage_mem_pkg::*;
(
   input  logic [7:0]  i_operator,
   input  logic [1:0]  i_addr_low,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_read_data,
   output logic [3:0]  o_byte_select,
   output logic [31:0] o_write_data,
   output logic [31:0] o_load_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      // Address 0 is the most significant lane
      w_byte = 8'h00;
      case (i_addr_low)
         2'd0:    w_byte = i_read_data[31:24];
         2'd1:    w_byte = i_read_data[23:16];
         2'd2:    w_byte = i_read_data[15:8];
         default: w_byte = i_read_data[7:0];
      endcase
      w_half = i_addr_low[1] ? i_read_data[15:0] : i_read_data[31:16];
   end

   always_comb begin
      o_byte_select = 4'hF;
      o_write_data  = i_store_data;
      o_load_data   = i_read_data;
      case (i_operator)
         OPERATOR_LB, OPERATOR_LBU, OPERATOR_SB: begin
            o_byte_select = 4'b1000 >> i_addr_low;
            o_write_data  = {4{i_store_data[7:0]}};
            o_load_data   = (i_operator == OPERATOR_LB) ? {{24{w_byte[7]}}, w_byte}
                                                        : {24'h000000, w_byte};
         end
         OPERATOR_LH, OPERATOR_LHU, OPERATOR_SH: begin
            // Halfword lane choice uses EA[1] only; EA[0] is ignored
            o_byte_select = i_addr_low[1] ? 4'b0011 : 4'b1100;
            o_write_data  = {2{i_store_data[15:0]}};
            o_load_data   = (i_operator == OPERATOR_LH) ? {{16{w_half[15]}}, w_half}
                                                        : {16'h0000, w_half};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/stage_mem.sv
// -----------------------------------------------------------------------------
// stage_mem
// Memory-access pipeline stage between the EX/MEM and MEM/WB latches. Decodes
// load/store operators, runs a request/acknowledge bus transaction and holds
// the pipeline with stall_request until the access completes. Register, HI and
// LO writeback fields pass through; loads substitute the aligned bus data.
//
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   instruction[15:0]            : signed memory offset
//   operator, operand_a/b        : operator code, base address, store data
//   register_*/register_hi_*/register_lo_* : writeback fields from EX
//   result_*                     : writeback fields to MEM/WB
//   stall_request                : hold upstream stages, bubble MEM/WB
//   bus_request/write/address/byte_select/write_data : registered bus request
//   bus_read_data, bus_acknowledge : bus response (one-cycle ack pulse)
//
// Build option: define MEM_LLSC_EN to add the LL/SC link register. Without it
// LL acts as LW and SC acts as SW that always reports success.
// -----------------------------------------------------------------------------
module stage_mem
   import stage_mem_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic [7:0]  operator,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   input  logic        register_write_enable,
   input  logic [4:0]  register_write_address,
   input  logic [31:0] register_write_data,
   input  logic        register_hi_write_enable,
   input  logic [31:0] register_hi_write_data,
   input  logic        register_lo_write_enable,
   input  logic [31:0] register_lo_write_data,
   output logic        result_register_write_enable,
   output logic [4:0]  result_register_write_address,
   output logic [31:0] result_register_write_data,
   output logic        result_register_hi_write_enable,
   output logic [31:0] result_register_hi_write_data,
   output logic        result_register_lo_write_enable,
   output logic [31:0] result_register_lo_write_data,
   output logic        stall_request,
   output logic        bus_request,
   output logic        bus_write,
   output logic [31:0] bus_address,
   output logic [3:0]  bus_byte_select,
   output logic [31:0] bus_write_data,
   input  logic [31:0] bus_read_data,
   input  logic        bus_acknowledge
);

   mem_state_t  r_state;
   mem_state_t  w_state_next;
   logic        r_bus_request;
   logic        r_bus_write;
   logic [31:0] r_bus_address;
   logic [3:0]  r_bus_byte_select;
   logic [31:0] r_bus_write_data;
   logic [31:0] r_read_data;

   logic [31:0] w_ea;
   logic        w_access;
   logic [31:0] w_sc_result;
   logic [3:0]  w_byte_select;
   logic [31:0] w_write_data;
   logic [31:0] w_load_data;
   logic        w_stall;
   logic        w_unused;

   // Upper instruction bits are decoded elsewhere
   assign w_unused = &{1'b0, instruction[31:16]};

   assign w_ea = operand_a + {{16{instruction[15]}}, instruction[15:0]};

`ifdef MEM_LLSC_EN
   logic r_link;

   // A failed SC never touches the bus and never stalls
   assign w_access    = op_is_mem(operator) && !((operator == OPERATOR_SC) && !r_link);
   // Link is cleared only at the DONE edge, so it still reads 1 throughout a
   // successful SC
   assign w_sc_result = {31'd0, r_link};

   always_ff @(posedge clock) begin
      if (reset == RESET_ENABLE) begin
         r_link <= 1'b0;
      end else if (r_state == MEM_STATE_DONE) begin
         if (operator == OPERATOR_LL) begin
            r_link <= 1'b1;
         end else if (operator == OPERATOR_SC) begin
            r_link <= 1'b0;
         end
      end
   end
`else
   assign w_access    = op_is_mem(operator);
   assign w_sc_result = 32'd1;
`endif

   mem_align u_mem_align (
      .i_operator    (operator),
      .i_addr_low    (w_ea[1:0]),
      .i_store_data  (operand_b),
      .i_read_data   (r_read_data),
      .o_byte_select (w_byte_select),
      .o_write_data  (w_write_data),
      .o_load_data   (w_load_data)
   );

   always_ff @(posedge clock) begin
      if (reset == RESET_ENABLE) begin
         r_state           <= MEM_STATE_IDLE;
         r_bus_request     <= 1'b0;
         r_bus_write       <= 1'b0;
         r_bus_address     <= 32'd0;
         r_bus_byte_select <= 4'd0;
         r_bus_write_data  <= 32'd0;
         r_read_data       <= 32'd0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            MEM_STATE_IDLE: begin
               if (w_access) begin
                  r_bus_request     <= 1'b1;
                  r_bus_write       <= op_is_store(operator);
                  r_bus_address     <= {w_ea[31:2], 2'b00};
                  r_bus_byte_select <= w_byte_select;
                  r_bus_write_data  <= w_write_data;
               end
            end
            MEM_STATE_WAIT: begin
               if (bus_acknowledge) begin
                  r_read_data   <= bus_read_data;
                  r_bus_request <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_stall      = STALL_DISABLE;
      case (r_state)
         MEM_STATE_IDLE: begin
            if (w_access) begin
               w_stall      = STALL_ENABLE;
               w_state_next = MEM_STATE_WAIT;
            end
         end
         MEM_STATE_WAIT: begin
            w_stall = STALL_ENABLE;
            if (bus_acknowledge) begin
               w_state_next = MEM_STATE_DONE;
            end
         end
         // DONE releases the stall, so the upstream latch advances this edge
         default: w_state_next = MEM_STATE_IDLE;
      endcase
   end

   always_comb begin
      result_register_write_data = register_write_data;
      if (op_is_load(operator)) begin
         result_register_write_data = w_load_data;
      end else if (operator == OPERATOR_SC) begin
         result_register_write_data = w_sc_result;
      end
   end

   assign result_register_write_enable    = register_write_enable;
   assign result_register_write_address   = register_write_address;
   assign result_register_hi_write_enable = register_hi_write_enable;
   assign result_register_hi_write_data   = register_hi_write_data;
   assign result_register_lo_write_enable = register_lo_write_enable;
   assign result_register_lo_write_data   = register_lo_write_data;

   assign stall_request   = w_stall;
   assign bus_request     = r_bus_request;
   assign bus_write       = r_bus_write;
   assign bus_address     = r_bus_address;
   assign bus_byte_select = r_bus_byte_select;
   assign bus_write_data  = r_bus_write_data;

endmodule

// File: tb/tb_stage_mem.sv
// -----------------------------------------------------------------------------
// tb_stage_mem
// Directed and randomized stimulus for stage_mem against a behavioural model
// of effective address, big-endian lanes, extension and stall timing.
// -----------------------------------------------------------------------------
module tb_stage_mem;
   import stage_mem_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] instruction;
   logic [7:0]  operator;
   logic [31:0] operand_a, operand_b;
   logic        register_write_enable;
   logic [4:0]  register_write_address;
   logic [31:0] register_write_data;
   logic        register_hi_write_enable;
   logic [31:0] register_hi_write_data;
   logic        register_lo_write_enable;
   logic [31:0] register_lo_write_data;
   logic        result_register_write_enable;
   logic [4:0]  result_register_write_address;
   logic [31:0] result_register_write_data;
   logic        result_register_hi_write_enable;
   logic [31:0] result_register_hi_write_data;
   logic        result_register_lo_write_enable;
   logic [31:0] result_register_lo_write_data;
   logic        stall_request;
   logic        bus_request, bus_write;
   logic [31:0] bus_address;
   logic [3:0]  bus_byte_select;
   logic [31:0] bus_write_data;
   logic [31:0] bus_read_data;
   logic        bus_acknowledge;

   int checks = 0;
   int errors = 0;
   bit link_m = 1'b0;

   always #5 clock = ~clock;

   stage_mem dut (
      .clock                           (clock),
      .reset                           (reset),
      .instruction                     (instruction),
      .operator                        (operator),
      .operand_a                       (operand_a),
      .operand_b                       (operand_b),
      .register_write_enable           (register_write_enable),
      .register_write_address          (register_write_address),
      .register_write_data             (register_write_data),
      .register_hi_write_enable        (register_hi_write_enable),
      .register_hi_write_data          (register_hi_write_data),
      .register_lo_write_enable        (register_lo_write_enable),
      .register_lo_write_data          (register_lo_write_data),
      .result_register_write_enable    (result_register_write_enable),
      .result_register_write_address   (result_register_write_address),
      .result_register_write_data      (result_register_write_data),
      .result_register_hi_write_enable (result_register_hi_write_enable),
      .result_register_hi_write_data   (result_register_hi_write_data),
      .result_register_lo_write_enable (result_register_lo_write_enable),
      .result_register_lo_write_data   (result_register_lo_write_data),
      .stall_request                   (stall_request),
      .bus_request                     (bus_request),
      .bus_write                       (bus_write),
      .bus_address                     (bus_address),
      .bus_byte_select                 (bus_byte_select),
      .bus_write_data                  (bus_write_data),
      .bus_read_data                   (bus_read_data),
      .bus_acknowledge                 (bus_acknowledge)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic bit m_load(input logic [7:0] op);
      return op inside {OPERATOR_LB, OPERATOR_LBU, OPERATOR_LH, OPERATOR_LHU,
                        OPERATOR_LW, OPERATOR_LL};
   endfunction

   function automatic bit m_store(input logic [7:0] op);
      return op inside {OPERATOR_SB, OPERATOR_SH, OPERATOR_SW, OPERATOR_SC};
   endfunction

   function automatic int m_size(input logic [7:0] op);
      if (op inside {OPERATOR_LB, OPERATOR_LBU, OPERATOR_SB}) return 1;
      if (op inside {OPERATOR_LH, OPERATOR_LHU, OPERATOR_SH}) return 2;
      return 4;
   endfunction

   function automatic logic [3:0] m_bsel(input logic [7:0] op, input logic [31:0] ea);
      int k;
      k = int'(ea[1:0]);
      if (m_size(op) == 1) return 4'(1 << (3 - k));
      if (m_size(op) == 2) return (k >= 2) ? 4'h3 : 4'hC;
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] b);
      if (m_size(op) == 1) return {4{b[7:0]}};
      if (m_size(op) == 2) return {2{b[15:0]}};
      return b;
   endfunction

   function automatic logic [31:0] m_load_val(input logic [7:0] op, input logic [31:0] ea,
                                              input logic [31:0] word);
      logic [31:0] v;
      int k;
      k = int'(ea[1:0]);
      if (m_size(op) == 1) begin
         v = (word >> (8 * (3 - k))) & 32'h0000_00FF;
         if (op == OPERATOR_LB && v[7]) v = v | 32'hFFFF_FF00;
      end else if (m_size(op) == 2) begin
         v = (k >= 2) ? (word & 32'h0000_FFFF) : (word >> 16);
         if (op == OPERATOR_LH && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = word;
      end
      return v;
   endfunction

   task automatic drive_fields(input logic [7:0] op, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd);
      operator                 = op;
      register_write_enable    = we;
      register_write_address   = wa;
      register_write_data      = wd;
      register_hi_write_enable = 1'($urandom);
      register_hi_write_data   = $urandom;
      register_lo_write_enable = 1'($urandom);
      register_lo_write_data   = $urandom;
   endtask

   task automatic check_pass(input string tag, input logic [31:0] exp_data);
      check({tag, "_we"},  result_register_write_enable,    register_write_enable);
      check({tag, "_wa"},  result_register_write_address,   register_write_address);
      check({tag, "_wd"},  result_register_write_data,      exp_data);
      check({tag, "_hwe"}, result_register_hi_write_enable, register_hi_write_enable);
      check({tag, "_hwd"}, result_register_hi_write_data,   register_hi_write_data);
      check({tag, "_lwe"}, result_register_lo_write_enable, register_lo_write_enable);
      check({tag, "_lwd"}, result_register_lo_write_data,   register_lo_write_data);
   endtask

   task automatic pass_op(input logic [7:0] op, input logic [4:0] wa, input logic [31:0] wd,
                          input string tag);
      drive_fields(op, 1'b1, wa, wd);
      instruction     = $urandom;
      operand_a       = $urandom;
      operand_b       = $urandom;
      bus_acknowledge = 1'($urandom);
      bus_read_data   = $urandom;
      #1;
      check_pass(tag, wd);
      check({tag, "_stall"}, stall_request, 1'b0);
      check({tag, "_breq"}, bus_request, 1'b0);
      step();
      check({tag, "_breq_next"}, bus_request, 1'b0);
      bus_acknowledge = 1'b0;
   endtask

   task automatic mem_op(input logic [7:0] op, input logic [31:0] a, input logic [15:0] off,
                         input logic [31:0] b, input logic [31:0] rd, input int waits,
                         input string tag);
      logic [31:0] ea, exp_res;
      bit access;
      int stalls;
      ea = a + {{16{off[15]}}, off};
      access = 1'b1;
`ifdef MEM_LLSC_EN
      if (op == OPERATOR_SC && !link_m) access = 1'b0;
`endif
      drive_fields(op, m_load(op) || (op == OPERATOR_SC), 5'($urandom), $urandom);
      instruction     = {16'($urandom), off};
      operand_a       = a;
      operand_b       = b;
      bus_acknowledge = 1'b0;
      bus_read_data   = $urandom;
      if (m_load(op))               exp_res = m_load_val(op, ea, rd);
      else if (op == OPERATOR_SC)   exp_res = access ? 32'd1 : 32'd0;
      else                          exp_res = register_write_data;
      #1;
      if (!access) begin
         check({tag, "_nostall"}, stall_request, 1'b0);
         check({tag, "_nobreq"}, bus_request, 1'b0);
         check_pass(tag, exp_res);
         step();
         check({tag, "_nobreq_next"}, bus_request, 1'b0);
         return;
      end
      stalls = 0;
      if (stall_request) stalls++;
      check({tag, "_idle_breq"}, bus_request, 1'b0);
      step();
      for (int w = 0; w <= waits; w++) begin
         if (stall_request) stalls++;
         check({tag, "_breq"}, bus_request, 1'b1);
         check({tag, "_addr"}, bus_address, {ea[31:2], 2'b00});
         check({tag, "_bsel"}, bus_byte_select, m_bsel(op, ea));
         check({tag, "_bwrite"}, bus_write, m_store(op));
         if (m_store(op)) check({tag, "_bwdata"}, bus_write_data, m_wdata(op, b));
         if (w == waits) begin
            bus_acknowledge = 1'b1;
            bus_read_data   = rd;
         end
         step();
         bus_acknowledge = 1'b0;
         bus_read_data   = $urandom;
         #1;
      end
      check({tag, "_done_stall"}, stall_request, 1'b0);
      check({tag, "_stall_cycles"}, stalls, waits + 2);
      check({tag, "_done_breq"}, bus_request, 1'b0);
      check_pass(tag, exp_res);
      if (op == OPERATOR_LL) link_m = 1'b1;
      if (op == OPERATOR_SC) link_m = 1'b0;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   logic [7:0] mem_ops [10];
   logic [7:0] alu_ops [5];

   initial begin
      mem_ops = '{OPERATOR_LB, OPERATOR_LBU, OPERATOR_LH, OPERATOR_LHU, OPERATOR_LW,
                  OPERATOR_SB, OPERATOR_SH, OPERATOR_SW, OPERATOR_LL, OPERATOR_SC};
      alu_ops = '{OPERATOR_NOP, OPERATOR_ADD, OPERATOR_SUB, OPERATOR_AND, OPERATOR_OR};

      // Reset with an all-zero NOP input
      reset = 1'b1;
      instruction = '0; operator = OPERATOR_NOP; operand_a = '0; operand_b = '0;
      register_write_enable = 1'b0; register_write_address = '0; register_write_data = '0;
      register_hi_write_enable = 1'b0; register_hi_write_data = '0;
      register_lo_write_enable = 1'b0; register_lo_write_data = '0;
      bus_read_data = '0; bus_acknowledge = 1'b0;
      step();
      step();
      reset = 1'b0;
      #1;
      check("rst_stall", stall_request, 1'b0);
      check("rst_breq", bus_request, 1'b0);
      check("rst_bwrite", bus_write, 1'b0);
      check("rst_addr", bus_address, 32'd0);
      check("rst_bsel", bus_byte_select, 4'd0);
      check("rst_bwdata", bus_write_data, 32'd0);
      check("rst_res_wd", result_register_write_data, 32'd0);
      check("rst_res_we", result_register_write_enable, 1'b0);
      check("rst_res_hwd", result_register_hi_write_data, 32'd0);

      // Pass-through ALU op
      pass_op(OPERATOR_ADD, 5'd3, 32'h1234_5678, "add");

      // LW with two wait cycles before the acknowledge
      mem_op(OPERATOR_LW, 32'h0000_0100, 16'h0004, 32'h0, 32'hDEAD_BEEF, 2, "lw");

      // Byte loads at the least significant lane
      mem_op(OPERATOR_LB,  32'h0000_0200, 16'h0003, 32'h0, 32'h0000_00F0, 0, "lb");
      mem_op(OPERATOR_LBU, 32'h0000_0200, 16'h0003, 32'h0, 32'h0000_00F0, 1, "lbu");
      check("lbu_value_model", m_load_val(OPERATOR_LB, 32'h203, 32'hF0), 32'hFFFF_FFF0);

      // Halfword store to the low half
      mem_op(OPERATOR_SH, 32'h0000_0300, 16'h0002, 32'hAAAA_1234, 32'h0, 0, "sh");
      check("sh_res_we", result_register_write_enable, 1'b0);

      // Negative offset with address wrap
      mem_op(OPERATOR_LH, 32'h0000_0001, 16'hFFFD, 32'h0, 32'h8001_7FFF, 0, "lh_wrap");

      // Reset while WAIT: access abandoned, later acknowledge ignored
      drive_fields(OPERATOR_LW, 1'b1, 5'd7, 32'h5555_5555);
      instruction = 32'h0000_0008; operand_a = 32'h0000_0400;
      #1;
      step();
      check("rstwait_breq_before", bus_request, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      drive_fields(OPERATOR_NOP, 1'b0, 5'd0, 32'h0);
      #1;
      check("rstwait_breq_after", bus_request, 1'b0);
      check("rstwait_addr_after", bus_address, 32'd0);
      check("rstwait_stall_after", stall_request, 1'b0);
      bus_acknowledge = 1'b1;
      bus_read_data   = 32'hFFFF_FFFF;
      step();
      bus_acknowledge = 1'b0;
      #1;
      check("rstwait_late_ack_breq", bus_request, 1'b0);
      check("rstwait_late_ack_stall", stall_request, 1'b0);
      mem_op(OPERATOR_LW, 32'h0000_0500, 16'h0000, 32'h0, 32'h0BAD_F00D, 1, "lw_after_rst");

      // LL then two SCs
      mem_op(OPERATOR_LL, 32'h0000_0600, 16'h0000, 32'h0, 32'hCAFE_0001, 0, "ll");
      mem_op(OPERATOR_SC, 32'h0000_0600, 16'h0000, 32'h1111_2222, 32'h0, 0, "sc1");
      mem_op(OPERATOR_SC, 32'h0000_0600, 16'h0000, 32'h3333_4444, 32'h0, 0, "sc2");

      // Randomized mix of memory and pass-through operators
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            pass_op(alu_ops[$urandom_range(0, 4)], 5'($urandom), $urandom, "rnd_alu");
         end else begin
            mem_op(mem_ops[$urandom_range(0, 9)], $urandom, 16'($urandom), $urandom,
                   $urandom, $urandom_range(0, 3), "rnd_mem");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
